// File: rtl/ex_muldiv_seq_pkg.sv
// Shared types for the RV32M multiply/divide sequencer in EX.
package muldiv_types;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_BUSY,
    MS_DONE
  } ms_state_t;

  localparam logic [31:0] MD_DIV0_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/ex_muldiv_seq_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              i_mode,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc,
  output logic              o_qbit
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  always_comb begin
    w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
    // Remainder after the left shift can be XLEN+1 bits wide before the compare.
    w_trial = i_acc[2*XLEN-1:XLEN-1];
    w_ge    = (w_trial >= {1'b0, i_opnd});
    w_diff  = w_trial[XLEN-1:0] - i_opnd;
    o_acc   = '0;
    o_qbit  = 1'b0;
    if (i_mode) begin
      o_qbit = w_ge;
      o_acc  = {(w_ge ? w_diff : w_trial[XLEN-1:0]), i_acc[XLEN-2:0], w_ge};
    end else if (i_acc[0]) begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end else begin
      o_acc = {1'b0, i_acc[2*XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// EX-stage RV32M sequencer: captures operands, iterates, stalls the pipe, presents result for one cycle.
module ex_muldiv_seq
  import muldiv_types::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(ITERS);

  ms_state_t       r_state, w_state_n;
  muldiv_funct3_t  r_f3, w_f3;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_opb, r_res;
  logic [2*XLEN-1:0] r_acc, w_acc_step, w_prod;
  logic            r_neg_q, r_neg_r;

  logic            w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_last, w_qbit;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_spec_res, w_quot, w_rem, w_fin;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_mode (r_f3[2]),
    .i_acc  (r_acc),
    .i_opnd (r_opb),
    .o_acc  (w_acc_step),
    .o_qbit (w_qbit)
  );

  always_comb begin
    w_f3    = muldiv_funct3_t'(funct3);
    w_a_neg = rs1[XLEN-1] & ((w_f3 == F3_MULH) | (w_f3 == F3_MULHSU) |
                             (w_f3 == F3_DIV)  | (w_f3 == F3_REM));
    w_b_neg = rs2[XLEN-1] & ((w_f3 == F3_MULH) | (w_f3 == F3_DIV) | (w_f3 == F3_REM));
    w_mag_a = w_a_neg ? -rs1 : rs1;
    w_mag_b = w_b_neg ? -rs2 : rs2;
    w_div0  = w_f3[2] & (rs2 == '0);
    w_ovf   = ((w_f3 == F3_DIV) | (w_f3 == F3_REM)) &
              (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);
    w_special  = w_div0 | w_ovf;
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = w_f3[1] ? rs1 : XLEN'(MD_DIV0_Q);
    else if (w_ovf)
      w_spec_res = w_f3[1] ? '0 : rs1;
  end

  // Product and quotient share the same sign flag (operand signs differ).
  always_comb begin
    w_last = (r_cnt == CW'(ITERS-1));
    w_prod = r_neg_q ? -w_acc_step : w_acc_step;
    w_quot = {w_acc_step[XLEN-1:1], w_qbit};
    w_rem  = w_acc_step[2*XLEN-1:XLEN];
    unique case (r_f3)
      F3_MUL:                        w_fin = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  w_fin = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               w_fin = r_neg_q ? -w_quot : w_quot;
      default:                       w_fin = r_neg_r ? -w_rem : w_rem;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      MS_IDLE: if (req && !flush) w_state_n = w_special ? MS_DONE : MS_BUSY;
      MS_BUSY: if (w_last) w_state_n = MS_DONE;
      MS_DONE: w_state_n = MS_IDLE;
      default: w_state_n = MS_IDLE;
    endcase
    if (flush) w_state_n = MS_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MS_IDLE;
      r_f3    <= F3_MUL;
      r_cnt   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_acc   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_state_n;
      unique case (r_state)
        MS_IDLE: if (req && !flush) begin
          r_f3    <= w_f3;
          r_opb   <= w_mag_b;
          r_acc   <= {{XLEN{1'b0}}, w_mag_a};
          r_cnt   <= '0;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_res   <= w_special ? w_spec_res : '0;
        end
        MS_BUSY: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_res <= w_fin;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done   = (r_state == MS_DONE) & ~flush;
    result = done ? r_res : '0;
    stall  = req & ~flush & (r_state != MS_DONE);
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed self-checking bench for ex_muldiv_seq.
module tb_ex_muldiv_seq;
  import muldiv_types::*;

  logic        clk = 1'b0;
  logic        rst, req, flush, stall, done;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, result;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_count = 0;
  bit op_active = 1'b0;
  int t_first, t_second;

  ex_muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_count++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // An op in flight must keep req high unless it is being flushed.
  always @(negedge clk)
    if (rst && op_active) check_eq("req_held", {31'b0, req | flush}, 32'd1);

  // Entered and left at posedge+1; returns in the IDLE cycle after done.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit hold_req, output int t_done);
    int done_cyc = 99;
    int n_st = 0;
    logic [31:0] got = '0;
    t_done = -1;
    funct3 = f3; rs1 = a; rs2 = b; req = 1'b1; flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (c == 0) check_eq({tag, "_res_idle"}, result, 32'd0);
      if (stall) n_st++;
      if (done) begin
        done_cyc = c; got = result; t_done = cyc_count;
        break;
      end
      if (c == 1) begin rs1 = ~a; rs2 = a ^ b ^ 32'h5A5A_1234; end
      if (c >= 1) op_active = 1'b1;
      @(posedge clk); #1;
    end
    op_active = 1'b0;
    check_eq({tag, "_lat"}, done_cyc, exp_lat);
    check_eq({tag, "_stall"}, n_st, exp_lat);
    check_eq({tag, "_res"}, got, exp_res);
    @(posedge clk); #1;
    check_eq({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
    if (!hold_req) req = 1'b0;
  endtask

  task automatic quiet(input string tag, input int n);
    int nd = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check_eq(tag, nd, 0);
  endtask

  initial begin
    int td;
    rst = 1'b0; req = 1'b1; flush = 1'b0; funct3 = '0; rs1 = 32'd7; rs2 = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_stall_req", {31'b0, stall}, 32'd1);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    req = 1'b0; #1;
    check_eq("rst_stall_noreq", {31'b0, stall}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    run_op("mul",     F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, td);
    run_op("mulhu",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, td);
    run_op("mulh",    F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 0, td);
    run_op("mulhsu",  F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, td);
    run_op("div",     F3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 0, td);
    run_op("rem",     F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 0, td);
    run_op("divu",    F3_DIVU,   32'd100,       32'd7,         32'd14,        33, 0, td);
    run_op("remu",    F3_REMU,   32'd100,       32'd7,         32'd2,         33, 0, td);
    run_op("divu0",   F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1,  0, td);
    run_op("rem0",    F3_REM,    32'd5,         32'd0,         32'd5,         1,  0, td);
    run_op("divovf",  F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0, td);
    run_op("removf",  F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  0, td);

    // Flush mid-BUSY
    funct3 = F3_MUL; rs1 = 32'd123; rs2 = 32'd456; req = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check_eq("flush_pre_stall", {31'b0, stall}, 32'd1);
    flush = 1'b1; #1;
    check_eq("flush_stall", {31'b0, stall}, 32'd0);
    check_eq("flush_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; req = 1'b0;
    quiet("flush_no_done", 40);
    run_op("post_flush", F3_MUL, 32'd3, 32'd4, 32'd12, 33, 0, td);

    // Back-to-back
    run_op("b2b_divu", F3_DIVU, 32'd9, 32'd3, 32'd3,  33, 1, t_first);
    run_op("b2b_mul",  F3_MUL,  32'd5, 32'd5, 32'd25, 33, 0, t_second);
    check_eq("b2b_spacing", t_second - t_first, 34);

    // Reset mid-BUSY
    funct3 = F3_MUL; rs1 = 32'hDEAD; rs2 = 32'hBEEF; req = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check_eq("rstmid_pre_stall", {31'b0, stall}, 32'd1);
    rst = 1'b0; req = 1'b0; #1;
    check_eq("rstmid_stall", {31'b0, stall}, 32'd0);
    check_eq("rstmid_done", {31'b0, done}, 32'd0);
    check_eq("rstmid_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    quiet("rstmid_no_done", 40);
    run_op("post_rst", F3_MUL, 32'd6, 32'd7, 32'd42, 33, 0, td);

    // Reset landing on the DONE cycle
    funct3 = F3_DIVU; rs1 = 32'd50; rs2 = 32'd0; req = 1'b1;
    @(posedge clk); #1;
    check_eq("rstdone_pre_res", result, 32'hFFFF_FFFF);
    rst = 1'b0; #1;
    check_eq("rstdone_done", {31'b0, done}, 32'd0);
    check_eq("rstdone_result", result, 32'd0);
    req = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    quiet("rstdone_no_done", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Sequencer for the RV32M multiply/divide path in EX.
- Captures operands when the EX stage presents an M-extension op.
- Runs a 32-iteration shift-add / restoring-divide datapath.
- Holds the pipeline stalled while the op runs, then presents a 32-bit result for one cycle so EX can forward it in place of the ALU output.
- Sits beside the ALU/CMP in EX. Driven by the EX control word and the ID/EX register values; feeds the hazard/stall logic.

## Interface
Parameters:
- XLEN, 32, operand/result width
- ITERS, 32, iterations per mul/div (must equal XLEN)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset; resets all state immediately
- req  in  1  EX holds an M-op; level, held until the done cycle
- funct3  in  3  muldiv_funct3_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- rs1  in  XLEN  operand a (reg_a)
- rs2  in  XLEN  operand b (reg_b)
- flush  in  1  branch/jump flush of EX; aborts the op
- stall  out  1  freeze IF/ID/EX/MEM buffers
- done  out  1  result valid this cycle
- result  out  XLEN  RV32M result; 0 when done=0

## Operation
States (ms_state_t): IDLE, BUSY, DONE.

IDLE
- On req=1 and flush=0, capture funct3, the operand magnitudes, and the sign flags.
- Signed ops: MULH both operands signed; MULHSU rs1 only; DIV/REM both.
- Clear the 64-bit accumulator/remainder and set the counter to 0.
- Next state: BUSY. Special cases go straight to DONE instead:
  - Divisor 0: DIV/DIVU → all-ones; REM/REMU → rs1.
  - DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF: DIV → 0x80000000; REM → 0.

BUSY
- Perform one iteration per cycle and increment the 5-bit counter.
- Multiply: if multiplier LSB is set, add the multiplicand to the upper half; shift the product right 1.
- Divide: shift {rem,quot} left 1; if rem ≥ divisor, subtract and set the quotient LSB.
- Counter == ITERS-1 → DONE.

DONE
- done=1, stall=0, result driven. Always → IDLE.

Result selection
- MUL → low product; MULH/MULHSU/MULHU → high product. Negate the 64-bit product if the sign flags differ.
- DIV/DIVU → quotient, negated if the operand signs differ (signed ops).
- REM/REMU → remainder, taking rs1's sign (signed ops).
- All arithmetic wraps mod 2^XLEN.

stall (combinational)
- stall = req & ~flush & ~(state==DONE).

Flush
- In any state, flush=1 → IDLE next cycle. done is suppressed. No result is produced.

Back-to-back ops
- The pipeline advances on the DONE cycle. A new req seen in the following IDLE cycle starts a fresh op.

Reset
- Asserting rst (low) at any time, including mid-BUSY → state=IDLE, counter=0, registers=0, done=0, result=0.
- stall follows the stall equation (0 unless req is high).

## Timing
- Normal op: req rises at cycle 0 (IDLE capture, stall=1).
  - BUSY occupies cycles 1–32 (stall=1).
  - DONE at cycle 33 (stall=0, done=1).
  - Total: 34 cycles, 33 stalled.
- Special case: capture at cycle 0 (stall=1), DONE at cycle 1.
- done is high for exactly one cycle per completed op.
- result is registered. It is not combinational from rs1/rs2 after capture.
- Operand changes on rs1/rs2 after the capture cycle are ignored.
- req dropping without flush during BUSY is illegal. Assert it in the bench.
- flush and the DONE cycle coincident: done is suppressed; → IDLE.

## Structure
- Package muldiv_types holds:
  - muldiv_funct3_t (values match RV32M funct3 encodings, 0–7)
  - ms_state_t
  - MD_DIV0_Q = 32'hFFFFFFFF
- Sub-module muldiv_step: combinational single iteration.
  - Inputs: mode (mul/div), 64-bit acc, 32-bit operand.
  - Outputs: next acc and quotient bit.
- ex_muldiv_seq holds the FSM, counter, operand/sign registers and result fixup.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB; stall high for 33 cycles; done on cycle 33.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU same operands → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/−1 → 0x80000000. Each done at cycle 1 (2-cycle op).
- flush at BUSY iteration 10 → IDLE next cycle; stall=0; no done. Subsequent MUL 3×4 → 12 with full 34-cycle latency.
- Back-to-back DIVU 9/3 then MUL 5×5 → results 3 then 25, done cycles 34 apart.
- rst low mid-BUSY → all outputs 0 immediately. After release, a new op completes normally.
